cascadable_updown_counter: RTL
==============================

Name: cascadable_updown_counter

Overview:
- Parametrised successor to the family's 8-bit loadable up/down counter.
- WIDTH-bit synchronous counter with the same 2-bit mode encoding (clear/down/load/up) and the same active-low enables.
- Adds a programmable modulo limit, a one-shot (stop-at-terminal) mode, a sticky wrap flag with acknowledge, and a clean ripple-carry output for cascading.
- Used for timers and address/step counters in the TTL-level simulation models.

Parameters:
- WIDTH, 8, counter width in bits (≥2).
- RESET_VALUE, 0, value loaded into q on reset.

Ports:
- clk, input, 1, rising-edge clock.
- asyncResetN, input, 1, reset: asynchronous, active-low.
- mode, input, 2, operation: 00 clear, 01 count down, 10 load, 11 count up.
- enpN, input, 1, count-enable P, active-low; not cascaded.
- entN, input, 1, count-enable T, active-low; cascaded, also gates rcoN.
- dataIn, input, WIDTH, parallel load value.
- limit, input, WIDTH, modulo top; the counter spans 0..limit.
- oneShot, input, 1, 1 = halt at terminal instead of wrapping.
- ackWrap, input, 1, clears the wrapped flag.
- q, output, WIDTH, counter value.
- rcoN, output, 1, ripple-carry-out, active-low, combinational.
- wrapped, output, 1, sticky: a wrap or halt has occurred.
- halted, output, 1, one-shot terminal reached, counting stopped.

Behaviour:
- Reset (asyncResetN=0), immediate and independent of clk:
  - q=RESET_VALUE, wrapped=0, halted=0, state=RUN.
  - rcoN follows its combinational rule on q.
- Enable: enabled = ~(enpN | entN). When enabled=0, q, state and halted hold. Clear and load are also gated by enabled, as in the existing family.
- Rising edge with enabled=1:
  - mode 00: q←0; state←RUN.
  - mode 10: q←dataIn, even if dataIn>limit; state←RUN.
  - mode 11, RUN:
    - q≥limit (terminal): if oneShot=0, q←0 and set wrapped; if oneShot=1, q holds, state←HALT, set wrapped.
    - otherwise q←q+1.
  - mode 01, RUN:
    - q==0 (terminal): if oneShot=0, q←limit and set wrapped; if oneShot=1, q holds, state←HALT, set wrapped.
    - otherwise q←q−1.
  - modes 01/11 in HALT: q holds. Only clear or load exits HALT.
- States: RUN, HALT. halted = (state==HALT), registered.
- Width and arithmetic:
  - All arithmetic is WIDTH bits and unsigned.
  - With limit=2^WIDTH−1 the counter is a plain binary counter.
  - With limit=0 the counter stays at 0; every enabled count is terminal (wraps, or halts if oneShot).
- rcoN = 0 iff entN=0 and one of:
  - mode=11 and q≥limit;
  - mode=01 and q==0.
  - Otherwise rcoN=1, including in modes 00/10 and when entN=1.
  - Must never latch; rcoN is fully defined in every mode.
  - Independent of enpN and of halted.
- wrapped:
  - Set on the edge where a terminal event occurs.
  - Cleared on a clock edge with ackWrap=1 (not gated by enables).
  - Simultaneous set and ack: set wins, so wrapped=1.
- Cascading: stage N+1 entN ← stage N rcoN; enpN, mode and clk are shared. Full-range limits give a 2·WIDTH-bit counter.
- Reset mid-count or while in HALT returns to RUN at RESET_VALUE on assertion, with no clock required.

Decomposition:
- Shared package cascadable_counter_pkg:
  - mode constants MODE_CLEAR=2'b00, MODE_DOWN=2'b01, MODE_LOAD=2'b10, MODE_UP=2'b11;
  - state enum RUN/HALT.
  - Other family counters reuse the package.
- Sub-module counter_terminal_detect (combinational):
  - inputs q, limit, mode, entN;
  - outputs termUp, termDown, rcoN;
  - shared by the next-state logic and the rcoN output.

Test Plan:
1. WIDTH=8, limit=255, mode=11, enables low, 260 clocks from reset → q wraps 255→0 on clock 256, ends at 4. rcoN=0 only while q=255. wrapped=1 after clock 256.
2. limit=9, mode=01 from q=0 → q sequence 9,8,…,0,9. rcoN low at q=0. ackWrap pulse with no wrap on the same edge → wrapped=0. Ack on the edge of a wrap → wrapped stays 1.
3. oneShot=1, limit=5, mode=11 from 0 → q stops at 5, halted=1 from clock 6. Further up clocks keep q=5. mode=10 with dataIn=2 → q=2, halted=0.
4. Load dataIn=200 with limit=100, then mode=11 → next edge q=0 and wrapped=1 (≥limit counts as terminal).
5. Two WIDTH=4 instances cascaded, limit=15, mode=11 for 300 clocks → combined {hi,lo}=300 mod 256=44. Upper stage advances only on edges where lower rcoN=0. enpN=1 freezes both stages.
6. asyncResetN pulsed low between clock edges while q=7 and halted=1 → q=0, halted=0, wrapped=0 immediately. mode=00 with entN=1 → q unchanged.

Source files
------------

// File: rtl/cascadable_counter_pkg.sv
// Shared definitions for the cascadable counter family: mode encoding and
// run/halt state.
package cascadable_counter_pkg;

   localparam logic [1:0] MODE_CLEAR = 2'b00;
   localparam logic [1:0] MODE_DOWN  = 2'b01;
   localparam logic [1:0] MODE_LOAD  = 2'b10;
   localparam logic [1:0] MODE_UP    = 2'b11;

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } cnt_state_e;

endpackage

// File: rtl/counter_terminal_detect.sv
// Terminal-count detection shared by the counter next-state logic and the
// ripple-carry output.
module counter_terminal_detect
   import cascadable_counter_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] q,
   input  logic [WIDTH-1:0] limit,
   input  logic [1:0]       mode,
   input  logic             entN,
   output logic             termUp,
   output logic             termDown,
   output logic             rcoN
);

   logic rco_active;

   always_comb begin
      // >= so a load above the limit still wraps on the next up count
      termUp     = (q >= limit);
      termDown   = (q == '0);
      rco_active = 1'b0;
      if (!entN) begin
         if (mode == MODE_UP)   rco_active = termUp;
         if (mode == MODE_DOWN) rco_active = termDown;
      end
      rcoN = ~rco_active;
   end

endmodule

// File: rtl/cascadable_updown_counter.sv
// WIDTH-bit loadable up/down counter with modulo limit, one-shot halt,
// sticky wrap flag and active-low ripple-carry for cascading.
//
// state | meaning
// RUN   | counting enabled in modes 01/11
// HALT  | one-shot terminal reached; only clear or load leaves
module cascadable_updown_counter
   import cascadable_counter_pkg::*;
#(
   parameter int               WIDTH       = 8,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             asyncResetN,
   input  logic [1:0]       mode,
   input  logic             enpN,
   input  logic             entN,
   input  logic [WIDTH-1:0] dataIn,
   input  logic [WIDTH-1:0] limit,
   input  logic             oneShot,
   input  logic             ackWrap,
   output logic [WIDTH-1:0] q,
   output logic             rcoN,
   output logic             wrapped,
   output logic             halted
);

   cnt_state_e       state_q, state_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic             wrapped_q, wrapped_d;
   logic             enabled;
   logic             wrap_set;
   logic             term_up, term_down;

   counter_terminal_detect #(.WIDTH(WIDTH)) u_term (
      .q        (q_q),
      .limit    (limit),
      .mode     (mode),
      .entN     (entN),
      .termUp   (term_up),
      .termDown (term_down),
      .rcoN     (rcoN)
   );

   assign enabled = ~(enpN | entN);

   always_ff @(posedge clk or negedge asyncResetN) begin
      if (!asyncResetN) begin
         state_q   <= RUN;
         q_q       <= RESET_VALUE;
         wrapped_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         q_q       <= q_d;
         wrapped_q <= wrapped_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      q_d      = q_q;
      wrap_set = 1'b0;
      if (enabled) begin
         case (mode)
            MODE_CLEAR: begin
               q_d     = '0;
               state_d = RUN;
            end
            MODE_LOAD: begin
               q_d     = dataIn;
               state_d = RUN;
            end
            MODE_UP: begin
               if (state_q == RUN) begin
                  if (term_up) begin
                     wrap_set = 1'b1;
                     if (oneShot) state_d = HALT;
                     else         q_d     = '0;
                  end else begin
                     q_d = q_q + 1'b1;
                  end
               end
            end
            default: begin
               if (state_q == RUN) begin
                  if (term_down) begin
                     wrap_set = 1'b1;
                     if (oneShot) state_d = HALT;
                     else         q_d     = limit;
                  end else begin
                     q_d = q_q - 1'b1;
                  end
               end
            end
         endcase
      end
      // a new wrap outranks an acknowledge on the same edge
      if (wrap_set)     wrapped_d = 1'b1;
      else if (ackWrap) wrapped_d = 1'b0;
      else              wrapped_d = wrapped_q;
   end

   always_comb begin
      halted  = (state_q == HALT);
      q       = q_q;
      wrapped = wrapped_q;
   end

endmodule
